// File: rtl/key_session_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_session_controller_pkg                                                  |
// | State encoding and default widths shared by the controller and its bench.  |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
package key_session_controller_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_TIMEOUT    = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_CALC = 2'd2,
        ST_SEND = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/key_session_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_session_controller_if                                                   |
// | Key decoder, serial command and datapath signals of the session controller.|
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
interface key_session_controller_if
    import key_session_controller_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  active;
    logic                  mode;
    logic                  valid_cmd;
    logic                  input_bit;
    logic                  result_valid;
    logic [DATA_WIDTH-1:0] result_in;
    logic                  key_clear;
    logic                  start_calc;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  mode_out;
    logic                  busy;
    logic                  serial_out;
    logic                  out_valid;
    logic                  error;

    modport master (
        output active, mode, valid_cmd, input_bit, result_valid, result_in,
        input  key_clear, start_calc, data_out, mode_out, busy, serial_out, out_valid, error
    );

    modport slave (
        input  active, mode, valid_cmd, input_bit, result_valid, result_in,
        output key_clear, start_calc, data_out, mode_out, busy, serial_out, out_valid, error
    );
endinterface
`default_nettype wire

// File: rtl/key_session_controller_serial_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_shift_reg                                                            |
// | W-bit MSB-first shift register with clear, parallel load and shift enable. |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module serial_shift_reg #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clear,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_data,
    input  wire logic             shift,
    input  wire logic             shift_in,
    output logic      [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], shift_in};
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_session_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_session_controller                                                      |
// | Runs one keyed session: receive word, start cipher, return result serially.|
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module key_session_controller
    import key_session_controller_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    key_session_controller_if.slave bus
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    state_t                state;
    logic [BW-1:0]         bit_cnt;
    logic [IW-1:0]         idle_cnt;
    logic                  key_clear;
    logic                  start_calc;
    logic                  mode_out;
    logic                  busy;
    logic                  out_valid;
    logic                  error;
    logic [DATA_WIDTH-1:0] recv_q;
    logic [DATA_WIDTH-1:0] send_q;

    logic last_bit;
    logic timeout_hit;
    logic recv_shift;
    logic recv_clear;
    logic send_load;
    logic send_shift;

    always_comb begin
        last_bit    = (bit_cnt == BW'(DATA_WIDTH - 1));
        timeout_hit = (idle_cnt == IW'(TIMEOUT - 1));
        recv_shift  = (state == ST_RECV) && bus.valid_cmd;
        // Abort wipes the partially collected or pending word
        recv_clear  = ((state == ST_RECV) && !bus.valid_cmd    && timeout_hit) ||
                      ((state == ST_CALC) && !bus.result_valid && timeout_hit);
        send_load   = (state == ST_CALC) && bus.result_valid;
        send_shift  = (state == ST_SEND);
    end

    serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_recv_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (recv_clear),
        .load      (1'b0),
        .load_data ('0),
        .shift     (recv_shift),
        .shift_in  (bus.input_bit),
        .q         (recv_q)
    );

    // Zero fill keeps serial_out low once the word has drained
    serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_send_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (1'b0),
        .load      (send_load),
        .load_data (bus.result_in),
        .shift     (send_shift),
        .shift_in  (1'b0),
        .q         (send_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            key_clear  <= 1'b0;
            start_calc <= 1'b0;
            mode_out   <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            error      <= 1'b0;
        end else begin
            key_clear  <= 1'b0;
            start_calc <= 1'b0;
            error      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.active) begin
                        state     <= ST_RECV;
                        mode_out  <= bus.mode;
                        bit_cnt   <= '0;
                        idle_cnt  <= '0;
                        key_clear <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (bus.valid_cmd) begin
                        bit_cnt  <= bit_cnt + BW'(1);
                        idle_cnt <= '0;
                        if (last_bit) begin
                            state      <= ST_CALC;
                            start_calc <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                ST_CALC: begin
                    if (bus.result_valid) begin
                        state     <= ST_SEND;
                        out_valid <= 1'b1;
                        bit_cnt   <= '0;
                        idle_cnt  <= '0;
                    end else if (timeout_hit) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                ST_SEND: begin
                    bit_cnt <= bit_cnt + BW'(1);
                    if (last_bit) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.key_clear  = key_clear;
    assign bus.start_calc = start_calc;
    assign bus.data_out   = recv_q;
    assign bus.mode_out   = mode_out;
    assign bus.busy       = busy;
    assign bus.serial_out = send_q[DATA_WIDTH-1];
    assign bus.out_valid  = out_valid;
    assign bus.error      = error;

endmodule
`default_nettype wire

// File: tb/tb_key_session_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_session_controller                                                   |
// | Session-level randomized bench with a transaction reference model.         |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_key_session_controller;
    import key_session_controller_pkg::*;

    localparam int W  = DEFAULT_DATA_WIDTH;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    key_session_controller_if #(.DATA_WIDTH(W)) bus ();

    key_session_controller #(.DATA_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge and settle; inputs are driven and outputs observed here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({bus.key_clear, bus.start_calc, bus.data_out, bus.mode_out,
                        bus.busy, bus.serial_out, bus.out_valid, bus.error}), 0);
    endtask

    task automatic quiet_inputs();
        bus.valid_cmd    = 1'b0;
        bus.input_bit    = 1'b0;
        bus.result_valid = 1'b0;
        bus.result_in    = '0;
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        bus.active = 1'b1;
        quiet_inputs();
        step();
        check_all_zero("rst_held_active");
        bus.active = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check_all_zero("rst_release");
        step();
        check_all_zero("rst_idle");
    endtask

    // One session. abort_bits>=0: stall after that many bits; res_delay<0: no result;
    // rst_recv/rst_send>=0: reset pulse after that many bits in/out.
    task automatic run_session(input logic m, input logic [W-1:0] word, input int max_gap,
                               input int abort_bits, input int res_delay,
                               input logic [W-1:0] result, input int rst_recv,
                               input int rst_send, input bit keep_active);
        logic exp_bits[$];
        for (int b = W - 1; b >= 0; b--) exp_bits.push_back(result[b]);

        bus.active = 1'b1;
        bus.mode   = m;
        quiet_inputs();
        step();
        check("start_busy", 32'(bus.busy), 1);
        check("start_key_clear", 32'(bus.key_clear), 1);
        check("start_mode_out", 32'(bus.mode_out), 32'(m));
        bus.mode = ~m;

        for (int k = 0; k < W; k++) begin
            if (k == rst_recv) begin
                reset_pulse();
                return;
            end
            if (k == abort_bits) begin
                bus.active = 1'b0;
                bus.valid_cmd = 1'b0;
                for (int c = 1; c <= TO; c++) begin
                    step();
                    check("recv_to_error", 32'(bus.error), (c == TO) ? 1 : 0);
                    check("recv_to_busy", 32'(bus.busy), (c == TO) ? 0 : 1);
                end
                check("recv_to_data", 32'(bus.data_out), 0);
                step();
                check("recv_to_err_pulse", 32'({bus.error, bus.busy, bus.key_clear}), 0);
                return;
            end
            bus.active = 1'($urandom);
            for (int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0; g > 0; g--) begin
                bus.valid_cmd = 1'b0;
                bus.input_bit = 1'($urandom);
                step();
                check("gap_no_error", 32'({bus.error, bus.key_clear, bus.out_valid}), 0);
            end
            bus.valid_cmd = 1'b1;
            bus.input_bit = word[W-1-k];
            step();
            check("recv_start_calc", 32'(bus.start_calc), (k == W - 1) ? 1 : 0);
            check("recv_quiet", 32'({bus.error, bus.key_clear, bus.out_valid}), 0);
        end
        check("calc_data_out", 32'(bus.data_out), 32'(word));
        check("calc_mode_hold", 32'(bus.mode_out), 32'(m));

        if (res_delay < 0) begin
            bus.active = 1'b0;
            for (int c = 1; c <= TO; c++) begin
                bus.valid_cmd = 1'($urandom);
                step();
                check("calc_to_error", 32'(bus.error), (c == TO) ? 1 : 0);
            end
            check("calc_to_idle", 32'({bus.busy, bus.data_out, bus.start_calc}), 0);
            step();
            check("calc_to_err_pulse", 32'(bus.error), 0);
            return;
        end
        for (int c = 0; c < res_delay; c++) begin
            bus.valid_cmd = 1'($urandom);
            bus.result_in = W'($urandom);
            step();
            check("calc_wait", 32'({bus.out_valid, bus.error, bus.start_calc}), 0);
        end
        bus.result_valid = 1'b1;
        bus.result_in    = result;
        step();

        for (int j = 0; j < W; j++) begin
            if (j == rst_send) begin
                reset_pulse();
                return;
            end
            check("send_valid", 32'({bus.out_valid, bus.busy}), 3);
            check("send_bit", 32'(bus.serial_out), 32'(exp_bits.pop_front()));
            check("send_data_hold", 32'(bus.data_out), 32'(word));
            bus.result_valid = 1'($urandom);
            bus.result_in    = W'($urandom);
            bus.valid_cmd    = 1'($urandom);
            bus.active       = (j == W - 1) ? keep_active : 1'($urandom);
            step();
        end
        check("send_done", 32'({bus.out_valid, bus.busy, bus.serial_out}), 0);
        quiet_inputs();
        if (keep_active) begin
            step();
            check("b2b_restart", 32'({bus.busy, bus.key_clear}), 3);
            bus.active = 1'b0;
            for (int k = 0; k < W; k++) begin
                bus.valid_cmd = 1'b1;
                step();
            end
            bus.valid_cmd = 1'b0;
            for (int c = 0; c < TO; c++) step();
            check("b2b_abort", 32'({bus.error, bus.busy}), 2);
        end else begin
            step();
            check("stay_idle", 32'({bus.busy, bus.key_clear}), 0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.active = 1'b1;
        bus.mode   = 1'b1;
        quiet_inputs();
        #12;
        check_all_zero("reset_state");
        step();
        check_all_zero("reset_active_held");
        bus.active = 1'b0;
        #2 rst_n = 1'b1;
        step();
        check_all_zero("idle_after_release");

        run_session(1'b1, 16'hA5C3, 0,      -1, 3,      16'h1234, -1, -1, 1'b0);
        run_session(1'b0, 16'hA5C3, TO - 1, -1, 0,      16'hBEEF, -1, -1, 1'b0);
        run_session(1'b1, 16'h0F0F, 2,       5, 0,      16'h0000, -1, -1, 1'b0);
        run_session(1'b0, 16'hFFFF, 0,       0, 0,      16'h0000, -1, -1, 1'b0);
        run_session(1'b1, 16'h8001, 1,      -1, -1,     16'h0000, -1, -1, 1'b0);
        run_session(1'b0, 16'h5A5A, 3,      -1, TO - 1, 16'hC001, -1, -1, 1'b0);
        run_session(1'b1, 16'h1357, 0,      -1, 1,      16'h2468,  7, -1, 1'b0);
        run_session(1'b0, 16'h9ABC, 0,      -1, 2,      16'hDEF0, -1,  5, 1'b0);
        run_session(1'b1, 16'h4321, 1,      -1, 0,      16'h8765, -1, -1, 1'b0);
        run_session(1'b0, 16'h7E7E, 0,      -1, 4,      16'h0101, -1, -1, 1'b1);

        for (int s = 0; s < 20; s++) begin
            int kind = int'($urandom_range(9, 0));
            run_session(1'($urandom), W'($urandom), int'($urandom_range(TO - 1, 0)),
                        (kind == 0) ? int'($urandom_range(W - 1, 0)) : -1,
                        (kind == 1) ? -1 : int'($urandom_range(TO - 1, 0)),
                        W'($urandom), -1, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
